// File: rtl/score_pkg.sv
// score_pkg
// Shared definitions for the score renderer: font cell geometry, the
// decimal digit type, a default-width BCD array type and the conversion
// FSM state encoding.
package score_pkg;

    localparam int FONT_W     = 8;
    localparam int FONT_H     = 16;
    localparam int DEF_DIGITS = 5;

    typedef logic [3:0] digit_t;

    // Index 0 is the least significant (ones) digit.
    typedef digit_t [DEF_DIGITS-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble binary to BCD converter, one input bit per clock.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : begin converting value (accepted only while idle)
//   value    : binary input, W bits
//   busy     : high from the start edge through the COMMIT cycle
//   done     : high during the single COMMIT cycle; bcd is final then
//   bcd      : N BCD digits, bcd[0] is the ones digit
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     value,
    output logic             busy,
    output logic             done,
    output digit_t [N-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);

    state_t          state;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    digit_t [N-1:0]  adj;

    // Add-3 correction applied to every nibble before each shift, so the
    // nibble stays a valid decimal digit after doubling.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < N; i++) begin
            if (bcd[i] >= 4'd5) begin
                adj[i] = bcd[i] + 4'd3;
            end
        end
    end

    // Conversion FSM. busy/done are registered alongside the state so they
    // track it exactly: busy covers SHIFT and COMMIT, done covers COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= value;
                        bcd   <= '0;
                        cnt   <= CW'(W);
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, shreg} <= {adj, shreg} << 1;
                    cnt          <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        done  <= 1'b1;
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/score_render.sv
// score_render
// Converts the binary game score to decimal and renders it through the
// digit font ROM as a registered per-pixel flag for the colour mapper.
// Ports:
//   Clk, Reset  : pixel clock and asynchronous active-high reset
//   score       : binary score value
//   score_load  : one-cycle request to convert and display score
//   DrawX/DrawY : current pixel column / row
//   font_addr   : registered font ROM address (digit*16 + row)
//   font_data   : ROM row for font_addr, bit 7 is the leftmost pixel
//   busy        : conversion in progress
//   score_on    : registered, current pixel is a lit score pixel
// Pixel latency from DrawX/DrawY to score_on is two clocks.
module score_render
    import score_pkg::*;
#(
    parameter int SCORE_W    = 16,
    parameter int NUM_DIGITS = 5,
    parameter int ORIGIN_X   = 16,
    parameter int ORIGIN_Y   = 16,
    parameter int BLANK_LEAD = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_load,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [10:0]        font_addr,
    input  logic [7:0]         font_data,
    output logic               busy,
    output logic               score_on
);

    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + FONT_W * NUM_DIGITS);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + FONT_H);

    logic                     conv_busy;
    logic                     conv_done;
    digit_t [NUM_DIGITS-1:0]  conv_bcd;
    digit_t [NUM_DIGITS-1:0]  disp;
    logic                     pending;
    logic [SCORE_W-1:0]       pend_val;
    logic                     start;
    logic [SCORE_W-1:0]       start_val;

    logic                     in_region;
    logic [9:0]               dx;
    logic [3:0]               row;
    digit_t                   sel_digit;
    logic                     sel_blank;
    logic                     zero_run;

    logic [2:0]               col_q;
    logic                     in_region_q;
    logic                     blank_q;

    // A fresh load while idle takes priority over an older pending value.
    assign start     = (score_load | pending) & ~conv_busy;
    assign start_val = score_load ? score : pend_val;
    assign busy      = conv_busy;

    bin2bcd_seq #(
        .W (SCORE_W),
        .N (NUM_DIGITS)
    ) u_bcd (
        .clk   (Clk),
        .rst   (Reset),
        .start (start),
        .value (start_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Display digits only change on the COMMIT cycle, so a frame never sees
    // a half-converted value. Loads arriving while busy (COMMIT included)
    // park in a one-deep pending slot, latest value wins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            disp     <= '0;
            pending  <= 1'b0;
            pend_val <= '0;
        end else begin
            if (conv_done) begin
                disp <= conv_bcd;
            end
            if (score_load && conv_busy) begin
                pending  <= 1'b1;
                pend_val <= score;
            end else if (start) begin
                pending <= 1'b0;
            end
        end
    end

    // Region test in 11 bits so pixels left of or above the origin never
    // wrap into the field. Row uses only the low nibble: inside the region
    // the offset is 0..15, so modulo-16 subtraction is exact.
    always_comb begin
        in_region = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                    ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
        dx        = DrawX - X_LO[9:0];
        row       = DrawY[3:0] - Y_LO[3:0];
    end

    // Screen digit i (0 = leftmost) shows disp[NUM_DIGITS-1-i]. It is blanked
    // when it and every digit to its left are zero, except the rightmost.
    always_comb begin
        sel_digit = '0;
        sel_blank = 1'b0;
        zero_run  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run & (disp[NUM_DIGITS-1-i] == 4'd0);
            if (dx[9:3] == 7'(i)) begin
                sel_digit = disp[NUM_DIGITS-1-i];
                sel_blank = (BLANK_LEAD != 0) && (i < NUM_DIGITS - 1) && zero_run;
            end
        end
    end

    // Stage 1 registers the ROM address plus the column, region and blank
    // qualifiers; stage 2 picks the glyph bit once the ROM row is back.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            font_addr   <= '0;
            col_q       <= '0;
            in_region_q <= 1'b0;
            blank_q     <= 1'b0;
            score_on    <= 1'b0;
        end else begin
            font_addr   <= in_region ? {3'b000, sel_digit, row} : 11'd0;
            col_q       <= dx[2:0];
            in_region_q <= in_region;
            blank_q     <= sel_blank;
            score_on    <= in_region_q & ~blank_q & font_data[3'd7 - col_q];
        end
    end

endmodule

// File: tb/tb_score_render.sv
// tb_score_render
// Directed self-checking bench for score_render. A second instance with
// leading-zero blanking disabled shares all inputs with the main one.
module tb_score_render;

    logic        Clk;
    logic        Reset;
    logic [15:0] score;
    logic        score_load;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [7:0]  font_data;
    logic [10:0] font_addr;
    logic        busy;
    logic        score_on;
    logic [10:0] font_addr_nb;
    logic        busy_nb;
    logic        score_on_nb;

    int compare_count  = 0;
    int mismatch_count = 0;
    int n;
    int busy_seen;

    score_render dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .score      (score),
        .score_load (score_load),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .busy       (busy),
        .score_on   (score_on)
    );

    score_render #(.BLANK_LEAD(0)) dut_nb (
        .Clk        (Clk),
        .Reset      (Reset),
        .score      (score),
        .score_load (score_load),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .font_addr  (font_addr_nb),
        .font_data  (font_data),
        .busy       (busy_nb),
        .score_on   (score_on_nb)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case something wedges the main sequence.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input logic [7:0] fd);
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        font_data = fd;
    endtask

    task automatic loadScore(input logic [15:0] val);
        score      = val;
        score_load = 1'b1;
        tick();
        score_load = 1'b0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    // Address is checked one clock after the pixel is presented, the lit
    // flag one clock later.
    task automatic pixelCheck(input string tag, input int x, input int y, input logic [7:0] fd,
                              input int exp_addr, input logic exp_on);
        applyStimulus(x, y, fd);
        tick();
        checkOutput({tag, "_addr"}, 32'(font_addr), 32'(exp_addr));
        tick();
        checkOutput({tag, "_on"}, 32'(score_on), 32'(exp_on));
    endtask

    initial begin
        Reset      = 1'b1;
        score      = '0;
        score_load = 1'b0;
        applyStimulus(0, 0, 8'h00);
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_addr", 32'(font_addr), 32'd0);
        checkOutput("rst_on", 32'(score_on), 32'd0);
        Reset = 1'b0;

        $display("[TB] reset display, rightmost zero lit, others blank");
        pixelCheck("rst_d4", 16 + 33, 16 + 2, 8'b01111100, 2, 1'b1);
        pixelCheck("rst_d0", 16 + 1, 16 + 2, 8'b01111100, 2, 1'b0);
        pixelCheck("rst_d3", 16 + 25, 16 + 2, 8'b01111100, 2, 1'b0);

        $display("[TB] converting 65535");
        loadScore(16'd65535);
        waitIdle(n);
        checkOutput("busy_len_65535", 32'(n), 32'd17);
        pixelCheck("d1_r5", 16 + 8, 16 + 5, 8'b10000000, 85, 1'b1);
        pixelCheck("d0_r0", 16 + 0, 16 + 0, 8'b10000000, 96, 1'b1);
        pixelCheck("d3_r15", 16 + 25, 16 + 15, 8'b10000000, 63, 1'b0);
        pixelCheck("d4_r1", 16 + 32, 16 + 1, 8'b10000000, 81, 1'b1);

        $display("[TB] back-to-back loads 12345 then 42");
        loadScore(16'd12345);
        tick();
        tick();
        loadScore(16'd42);
        waitIdle(n);
        checkOutput("first_done", 32'(n), 32'd14);
        pixelCheck("p12345_d0", 16 + 0, 16 + 0, 8'b10000000, 16, 1'b1);
        checkOutput("pend_started", 32'(busy), 32'd1);
        waitIdle(n);
        checkOutput("second_done", 32'(n), 32'd16);
        pixelCheck("p42_d2", 16 + 16, 16 + 4, 8'hFF, 4, 1'b0);
        pixelCheck("p42_d3", 16 + 24, 16 + 4, 8'hFF, 68, 1'b1);
        pixelCheck("p42_d4", 16 + 32, 16 + 0, 8'hFF, 32, 1'b1);

        $display("[TB] field boundaries");
        pixelCheck("x_left", 15, 20, 8'hFF, 0, 1'b0);
        pixelCheck("x_right", 56, 20, 8'hFF, 0, 1'b0);
        pixelCheck("y_below", 50, 32, 8'hFF, 0, 1'b0);
        pixelCheck("x_zero", 0, 0, 8'hFF, 0, 1'b0);
        pixelCheck("x_last", 55, 16, 8'b00000001, 32, 1'b1);
        pixelCheck("y_last", 55, 31, 8'b00000001, 47, 1'b1);

        $display("[TB] reset during conversion of 999");
        applyStimulus(16 + 24, 16, 8'hFF);
        loadScore(16'd999);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        checkOutput("pre_rst_on", 32'(score_on), 32'd1);
        Reset = 1'b1;
        #1;
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_on", 32'(score_on), 32'd0);
        checkOutput("async_addr", 32'(font_addr), 32'd0);
        tick();
        Reset = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        checkOutput("no_resume", 32'(busy_seen), 32'd0);
        pixelCheck("post_d4", 16 + 32, 16, 8'hFF, 0, 1'b1);
        pixelCheck("post_d2", 16 + 16, 16, 8'hFF, 0, 1'b0);

        $display("[TB] score 7 with and without blanking");
        loadScore(16'd7);
        waitIdle(n);
        checkOutput("busy_len_7", 32'(n), 32'd17);
        applyStimulus(16 + 1, 16 + 3, 8'hFF);
        tick();
        checkOutput("nb_d0_addr", 32'(font_addr_nb), 32'd3);
        tick();
        checkOutput("nb_d0_on", 32'(score_on_nb), 32'd1);
        checkOutput("bl_d0_on", 32'(score_on), 32'd0);
        applyStimulus(16 + 32, 16 + 3, 8'hFF);
        tick();
        checkOutput("nb_d4_addr", 32'(font_addr_nb), 32'd115);
        checkOutput("bl_d4_addr", 32'(font_addr), 32'd115);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/score_render.md
Name: score_render

Overview:
- Drives the digit font ROM from the read side. Converts the binary game score to decimal digits with a sequential double-dabble unit.
- For each VGA pixel, forms the font ROM address (digit*16 + row) and picks the glyph bit to produce a registered score-pixel flag for the colour mapper.
- Sits between the game-state logic (score source) and the colour mapper. Owns the font ROM address bus.

Parameters:
- SCORE_W, 16, width of the binary score input.
- NUM_DIGITS, 5, number of decimal digits displayed (must cover 2^SCORE_W-1).
- ORIGIN_X, 16, left pixel column of the score field.
- ORIGIN_Y, 16, top pixel row of the score field.
- BLANK_LEAD, 1, 1 = suppress leading zeros. The rightmost digit is always shown.

Ports:
- Clk, in, 1, pixel/system clock.
- Reset, in, 1, asynchronous active-high reset.
- score, in, SCORE_W, binary score value.
- score_load, in, 1, one-cycle request to convert and display score.
- DrawX, in, 10, current pixel column.
- DrawY, in, 10, current pixel row.
- font_addr, out, 11, registered font ROM address.
- font_data, in, 8, ROM row pattern for font_addr; bit 7 is the leftmost pixel.
- busy, out, 1, conversion in progress.
- score_on, out, 1, registered: current pixel is a lit score pixel.

Behaviour:
- Reset (async, immediate): FSM to IDLE; shift and BCD registers to 0; displayed digits all 0; pending flag 0; busy 0; font_addr 0; score_on 0; pipeline valid flags 0.
- FSM states are IDLE, SHIFT, COMMIT.
- IDLE to SHIFT on score_load, or on a set pending flag. Loads the shift register with score (or the pending value), clears BCD, sets the counter to SCORE_W.
- SHIFT, one bit per cycle:
  - First, each BCD nibble >= 5 gets +3.
  - Then {bcd, shift} shifts left 1 and the counter decrements.
  - When the counter reaches 0, go to COMMIT.
- COMMIT (1 cycle): copy BCD into the displayed digit registers, then return to IDLE.
- busy is high in SHIFT and COMMIT. Load-to-display latency is SCORE_W+1 cycles after the load edge (17 by default).
- score_load while busy: latch score into a one-deep pending register and set the pending flag. A later load overwrites it (latest wins). The pending flag clears when its conversion starts.
- score_load in the same cycle as COMMIT is treated as pending. The next conversion starts on the following IDLE cycle.
- Displayed digits change only in COMMIT, so a frame never shows a half-converted value.
- Leading-zero blanking: digit i (0 = leftmost, most significant) is blank when BLANK_LEAD=1, i < NUM_DIGITS-1, and digits 0..i are all zero.
- Pixel pipeline:
  - Stage 1 (edge n): in_region = DrawX in [ORIGIN_X, ORIGIN_X+8*NUM_DIGITS) and DrawY in [ORIGIN_Y, ORIGIN_Y+16).
  - The same edge registers: dx = DrawX-ORIGIN_X; digit index = dx[..:3]; col = dx[2:0]; row = DrawY-ORIGIN_Y (4 bits).
  - font_addr = digit_value*16 + row, zero-extended to 11 bits, plus col, in_region and blank, all registered.
  - Outside the region, font_addr holds 0 and in_region is 0.
  - Stage 2 (edge n+1): score_on = in_region_q & ~blank_q & font_data[7-col_q].
  - Total pixel latency is 2 clocks. The colour mapper delays its other layers to match.
- Subtractions are done in 11-bit signed or with an explicit compare first. No wrap-around on DrawX < ORIGIN_X.
- Reset mid-conversion: the conversion is abandoned and the display shows 0 (or a single "0" with blanking).

Decomposition:
- Shared package score_pkg holds FONT_W=8, FONT_H=16, the digit typedef (logic [3:0]), the BCD-array typedef, and the FSM state enum.
- One sub-module, bin2bcd_seq: the sequential double-dabble with start/busy/done and a BCD output. score_render instantiates it and keeps the display registers, pending logic and pixel pipeline.

Test Plan:
- Reset then no load. Pixel (ORIGIN_X+33, ORIGIN_Y+2), i.e. digit 4 col 1 row 2 -> font_addr 2 after 1 clk; with font_data 8'b01111100, score_on=1 after 2 clks. Digits 0-3 give score_on=0 (blanked).
- score=65535, score_load pulse -> busy high for exactly 17 cycles. Displayed digits 6,5,5,3,5. Pixel at digit 1 row 5 -> font_addr 85.
- score=12345 loaded, then score=42 loaded 3 cycles later -> 12345 commits first. 42 starts the cycle after returning to IDLE and commits; final digits 0,0,0,4,2 with the first three blanked.
- Assert Reset at cycle 8 of a conversion of 999 -> busy=0 and score_on=0 immediately. Digits read 0 and no COMMIT of 999 occurs.
- Boundaries: DrawX=ORIGIN_X-1, ORIGIN_X+40, and DrawY=ORIGIN_Y+16 -> score_on=0 and font_addr=0. DrawX=ORIGIN_X+39 with a lit bit -> score_on=1.
- BLANK_LEAD=0 with score=7 -> all five digits rendered. font_addr for digit 0 row 3 = 3.
